neuron_mac_lanes: RTL



---
 rtl/neuron_mac_lanes.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/neuron_mac_lanes.sv
// Multi-lane fixed-point neuron: LANES samples per beat are multiplied against
// locally stored weights, accumulated with signed saturation, biased, passed
// through ReLU or linear activation, and held on a valid/ready output.
// The weight memory and the bias register sit outside reset, so a reset that
// aborts a run keeps the loaded model parameters.

module neuron_mac_lane #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic signed [DATA_WIDTH-1:0]   sample,
   input  logic signed [DATA_WIDTH-1:0]   weight,
   output logic signed [2*DATA_WIDTH-1:0] prod
);
   localparam int PW = 2 * DATA_WIDTH;

   // Register the full-precision product of one accepted lane sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)    prod <= '0;
      else if (en) prod <= PW'(sample) * PW'(weight);
   end
endmodule

module neuron_mac_lanes #(
   parameter int    LAYER_NO         = 1,
   parameter int    NEURON_NO        = 0,
   parameter int    NUM_WEIGHT       = 30,
   parameter int    LANES            = 2,
   parameter int    DATA_WIDTH       = 16,
   parameter int    WEIGHT_INT_WIDTH = 1,
   parameter string ACT_TYPE         = "relu"
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        weight_valid,
   input  logic                        bias_valid,
   input  logic [31:0]                 weight_value,
   input  logic [31:0]                 bias_value,
   input  logic [31:0]                 config_layer_num,
   input  logic [31:0]                 config_neuron_num,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy
);
   localparam int DW        = DATA_WIDTH;
   localparam int PW        = 2 * DW;
   localparam int SW        = PW + $clog2(LANES);
   localparam int XW        = SW + 1;
   localparam int SHIFT     = DW - WEIGHT_INT_WIDTH;
   localparam int NUM_BEATS = (NUM_WEIGHT + LANES - 1) / LANES;
   localparam int BW        = $clog2(NUM_BEATS + 1);
   localparam int PTRW      = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
   localparam int STAGES    = 1;
   localparam bit IS_RELU   = (ACT_TYPE == "relu");

   localparam logic [31:0]            LAYER_SEL  = LAYER_NO;
   localparam logic [31:0]            NEURON_SEL = NEURON_NO;
   localparam logic signed [PW-1:0]   ACC_MAX    = {1'b0, {(PW-1){1'b1}}};
   localparam logic signed [PW-1:0]   ACC_MIN    = {1'b1, {(PW-1){1'b0}}};
   localparam logic signed [XW-1:0]   ACC_MAX_X  = XW'(ACC_MAX);
   localparam logic signed [XW-1:0]   ACC_MIN_X  = XW'(ACC_MIN);
   localparam logic signed [DW-1:0]   D_MAX      = {1'b0, {(DW-1){1'b1}}};
   localparam logic signed [DW-1:0]   D_MIN      = {1'b1, {(DW-1){1'b0}}};
   localparam logic signed [PW-1:0]   D_MAX_X    = PW'(D_MAX);
   localparam logic signed [PW-1:0]   D_MIN_X    = PW'(D_MIN);

   typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_DRAIN, S_BIAS, S_OUT} state_t;

   state_t                        state, state_nxt;
   logic [BW-1:0]                 beat_cnt;
   logic                          drain_cnt;
   logic                          accept, last_beat, out_fire;
   logic [STAGES:1]               vld_q;
   logic [STAGES:0]               vld_pipe;
   logic [PTRW-1:0]               wptr;
   logic                          sel, wr_w, wr_b;
   logic [DW-1:0]                 wmem [NUM_WEIGHT];
   logic signed [DW-1:0]          bias;
   logic [LANES-1:0][DW-1:0]      lane_x, lane_w;
   logic [LANES-1:0][PW-1:0]      lane_p;
   logic signed [SW-1:0]          lane_sum, bias_sh, addend;
   logic signed [XW-1:0]          acc_sum;
   logic signed [PW-1:0]          acc, acc_sat, act_sh;
   logic [DW-1:0]                 act_r;
   logic                          unused_bits;

   assign unused_bits = ^{weight_value[31:DW], bias_value[31:DW]};
   assign lane_x      = in_data;
   assign vld_pipe    = {vld_q, accept};
   assign out_fire    = (state == S_OUT) && out_ready;

   assign sel  = (config_layer_num == LAYER_SEL) && (config_neuron_num == NEURON_SEL);
   assign wr_w = weight_valid && sel && (state == S_IDLE);
   assign wr_b = bias_valid && sel && (state == S_IDLE);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Next state, input handshake and busy
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      busy      = (state != S_IDLE);
      last_beat = (beat_cnt == BW'(NUM_BEATS - 1));
      case (state)
         S_IDLE:  in_ready = 1'b1;
         S_ACCUM: in_ready = (beat_cnt < BW'(NUM_BEATS));
         default: in_ready = 1'b0;
      endcase
      accept = in_valid && in_ready;
      case (state)
         S_IDLE, S_ACCUM: if (accept) state_nxt = last_beat ? S_DRAIN : S_ACCUM;
         S_DRAIN:         if (drain_cnt) state_nxt = S_BIAS;
         S_BIAS:          state_nxt = S_OUT;
         S_OUT:           if (out_ready) state_nxt = S_IDLE;
         default:         state_nxt = S_IDLE;
      endcase
   end

   // Pick each lane's weight for the current beat; lanes past the last weight see 0
   always_comb begin
      lane_w = '0;
      for (int l = 0; l < LANES; l++)
         for (int b = 0; b < NUM_BEATS; b++)
            if ((b * LANES + l < NUM_WEIGHT) && (beat_cnt == BW'(b)))
               lane_w[l] = wmem[PTRW'((b * LANES + l) % NUM_WEIGHT)];
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      neuron_mac_lane #(.DATA_WIDTH(DW)) u_lane (
         .clk    (clk),
         .rst    (rst),
         .en     (vld_pipe[0]),
         .sample (lane_x[l]),
         .weight (lane_w[l]),
         .prod   (lane_p[l])
      );
   end

   // Sum the registered lane products, then one saturating adder serves both
   // beat accumulation and the bias step (they never coincide)
   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < LANES; l++) lane_sum = lane_sum + SW'($signed(lane_p[l]));
      bias_sh = SW'(bias) <<< SHIFT;
      addend  = (state == S_BIAS) ? bias_sh : lane_sum;
      acc_sum = XW'(acc) + XW'(addend);
      if (acc_sum > ACC_MAX_X)      acc_sat = ACC_MAX;
      else if (acc_sum < ACC_MIN_X) acc_sat = ACC_MIN;
      else                          acc_sat = acc_sum[PW-1:0];
   end

   // Rescale the biased accumulator to the output format and apply activation
   always_comb begin
      act_sh = acc_sat >>> SHIFT;
      if (act_sh > D_MAX_X)      act_r = D_MAX;
      else if (act_sh < D_MIN_X) act_r = D_MIN;
      else                       act_r = act_sh[DW-1:0];
      if (IS_RELU && act_r[DW-1]) act_r = '0;
   end

   // Beat counter, drain timer, valid pipeline and weight pointer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt  <= '0;
         drain_cnt <= 1'b0;
         vld_q     <= '0;
         wptr      <= '0;
      end else begin
         vld_q     <= vld_pipe[STAGES-1:0];
         drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
         if (wr_w) wptr <= (wptr == PTRW'(NUM_WEIGHT - 1)) ? '0 : wptr + PTRW'(1);
         if (out_fire)    beat_cnt <= '0;
         else if (accept) beat_cnt <= beat_cnt + BW'(1);
      end
   end

   // Accumulator: add in-flight lane sums and the bias, clear after the result is taken
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                      acc <= '0;
      else if (out_fire)                             acc <= '0;
      else if (vld_pipe[STAGES] || state == S_BIAS)  acc <= acc_sat;
   end

   // Output register: captured on entry to OUT, held until the handshake
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (state == S_BIAS) begin
         out_valid <= 1'b1;
         out_data  <= act_r;
      end else if (out_fire) begin
         out_valid <= 1'b0;
      end
   end

   // Weight memory and bias register, writable only while idle
   always_ff @(posedge clk) begin
      if (wr_w) wmem[wptr] <= weight_value[DW-1:0];
      if (wr_b) bias <= bias_value[DW-1:0];
   end
endmodule
